// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer RAM port arbiter: display fetch, fill engine, writer FIFO
//
// Shares the single frame-buffer RAM port between hard-real-time display
// scan-out and a pixel writer (valid/ready, WFIFO_DEPTH-entry FIFO), plus an
// optional whole-frame fill engine enabled by defining FB_PORT_CLEAR_EN.
//
// Ports:
//   clk, rst_                 clock, asynchronous active-low reset
//   iDE, iHADDR, iVADDR       LCD timing: active video, column 0..799, row 0..479
//   oPIX, oPIX_VLD            scan-out word and its valid flag (3-cycle latency)
//   iWR_VALID, oWR_READY      writer handshake
//   iWR_ADDR, iWR_DATA, iWR_BE writer word address, data, byte enables
//   iCLR_START, iCLR_COLOR    fill start pulse and colour
//   oCLR_BUSY                 fill in progress
//   oADDR_ERR                 sticky out-of-range write flag
//   oRAM_*                    registered RAM port; iRAM_RDATA valid 1 cycle after address
module fb_port_arbiter #(
  parameter int FB_W        = 400,
  parameter int FB_H        = 240,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int WFIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              iDE,
  input  logic [9:0]        iHADDR,
  input  logic [8:0]        iVADDR,
  output logic [DATA_W-1:0] oPIX,
  output logic              oPIX_VLD,
  input  logic              iWR_VALID,
  output logic              oWR_READY,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  input  logic [1:0]        iWR_BE,
  input  logic              iCLR_START,
  input  logic [DATA_W-1:0] iCLR_COLOR,
  output logic              oCLR_BUSY,
  output logic              oADDR_ERR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic              oRAM_WRITE,
  output logic [DATA_W-1:0] oRAM_WDATA,
  output logic [1:0]        oRAM_BE,
  output logic              oRAM_CLKEN,
  input  logic [DATA_W-1:0] iRAM_RDATA
);

  localparam int                FB_SIZE   = FB_W * FB_H;
  localparam int                PTR_W     = $clog2(WFIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  // Display fetch: one RAM word covers a 2x2 pixel block, so only even
  // columns fetch and odd columns reuse the word already in oPIX.
  logic              disp_slot;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_vaddr0;

  assign disp_slot     = iDE & ~iHADDR[0];
  assign fetch_addr    = ADDR_W'(iVADDR[8:1]) * ADDR_W'(FB_W) + ADDR_W'(iHADDR[9:1]);
  assign unused_vaddr0 = iVADDR[0];

  // Writer FIFO
  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [1:0]        fifo_be   [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              push, pop, fifo_nonempty, head_in_range;
  logic [ADDR_W-1:0] head_addr;

  // Fill engine signals (constant when the engine is not built)
  logic              fill_active, fill_wr;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_color;

  assign oWR_READY     = (count < (PTR_W+1)'(WFIFO_DEPTH));
  assign push          = iWR_VALID & oWR_READY;
  assign fifo_nonempty = (count != '0);
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_in_range = (head_addr < ADDR_LIM);
  assign fill_wr       = fill_active & ~disp_slot;
  // The FIFO wins the port only when neither display nor fill wants it.
  assign pop           = fifo_nonempty & ~disp_slot & ~fill_active;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= iWR_ADDR;
      fifo_data[wr_ptr] <= iWR_DATA;
      fifo_be[wr_ptr]   <= iWR_BE;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

`ifdef FB_PORT_CLEAR_EN
  typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_t;
  fill_state_t fill_state, fill_next;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) fill_state <= FILL_IDLE;
    else       fill_state <= fill_next;
  end

  always_comb begin
    fill_next = fill_state;
    case (fill_state)
      FILL_IDLE: if (iCLR_START) fill_next = FILL_RUN;
      FILL_RUN:  if (fill_wr && fill_cnt == LAST_ADDR) fill_next = FILL_IDLE;
      default:   fill_next = FILL_IDLE;
    endcase
  end

  // Colour is captured only on an accepted start; a start during FILL is ignored.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fill_cnt   <= '0;
      fill_color <= '0;
    end else if (fill_state == FILL_IDLE && iCLR_START) begin
      fill_cnt   <= '0;
      fill_color <= iCLR_COLOR;
    end else if (fill_wr) begin
      fill_cnt <= fill_cnt + ADDR_W'(1);
    end
  end

  assign fill_active = (fill_state == FILL_RUN);
  assign oCLR_BUSY   = fill_active;
`else
  logic unused_clr;
  assign unused_clr  = ^{iCLR_START, iCLR_COLOR};
  assign fill_active = 1'b0;
  assign fill_cnt    = '0;
  assign fill_color  = '0;
  assign oCLR_BUSY   = 1'b0;
`endif

  // Slot decision for the next port cycle. Idle cycles read address 0.
  logic [ADDR_W-1:0] port_addr;
  logic              port_write;
  logic [DATA_W-1:0] port_wdata;
  logic [1:0]        port_be;

  always_comb begin
    port_addr  = '0;
    port_write = 1'b0;
    port_wdata = '0;
    port_be    = 2'b00;
    if (disp_slot) begin
      port_addr = fetch_addr;
    end else if (fill_wr) begin
      port_addr  = fill_cnt;
      port_write = 1'b1;
      port_wdata = fill_color;
      port_be    = 2'b11;
    end else if (pop && head_in_range) begin
      port_addr  = head_addr;
      port_write = 1'b1;
      port_wdata = fifo_data[rd_ptr];
      port_be    = fifo_be[rd_ptr];
    end
  end

  // Scan-out pipeline: decide (t) -> RAM address (t+1) -> RAM data (t+2) -> oPIX (t+3)
  logic fetch_d1, fetch_d2, de_d1, de_d2;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      oRAM_ADDR  <= '0;
      oRAM_WRITE <= 1'b0;
      oRAM_WDATA <= '0;
      oRAM_BE    <= 2'b00;
      oRAM_CLKEN <= 1'b0;
      oADDR_ERR  <= 1'b0;
      fetch_d1   <= 1'b0;
      fetch_d2   <= 1'b0;
      de_d1      <= 1'b0;
      de_d2      <= 1'b0;
      oPIX       <= '0;
      oPIX_VLD   <= 1'b0;
    end else begin
      oRAM_ADDR  <= port_addr;
      oRAM_WRITE <= port_write;
      oRAM_WDATA <= port_wdata;
      oRAM_BE    <= port_be;
      oRAM_CLKEN <= 1'b1;
      if (pop && !head_in_range) oADDR_ERR <= 1'b1;
      fetch_d1   <= disp_slot;
      fetch_d2   <= fetch_d1;
      de_d1      <= iDE;
      de_d2      <= de_d1;
      oPIX_VLD   <= de_d2;
      if (fetch_d2) oPIX <= iRAM_RDATA;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - self-checking bench for fb_port_arbiter
`timescale 1ns/1ps
module tb_fb_port_arbiter;

`ifdef FB_PORT_CLEAR_EN
  localparam int FB_W_T = 40;
  localparam int FB_H_T = 24;
`else
  localparam int FB_W_T = 400;
  localparam int FB_H_T = 240;
`endif
  localparam int FB_SIZE_T = FB_W_T * FB_H_T;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        iDE = 1'b0;
  logic [9:0]  iHADDR = '0;
  logic [8:0]  iVADDR = '0;
  logic [15:0] oPIX;
  logic        oPIX_VLD;
  logic        iWR_VALID = 1'b0;
  logic        oWR_READY;
  logic [16:0] iWR_ADDR = '0;
  logic [15:0] iWR_DATA = '0;
  logic [1:0]  iWR_BE = '0;
  logic        iCLR_START = 1'b0;
  logic [15:0] iCLR_COLOR = '0;
  logic        oCLR_BUSY;
  logic        oADDR_ERR;
  logic [16:0] oRAM_ADDR;
  logic        oRAM_WRITE;
  logic [15:0] oRAM_WDATA;
  logic [1:0]  oRAM_BE;
  logic        oRAM_CLKEN;
  logic [15:0] iRAM_RDATA = '0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.FB_W(FB_W_T), .FB_H(FB_H_T)) dut (
    .clk(clk), .rst_(rst_), .iDE(iDE), .iHADDR(iHADDR), .iVADDR(iVADDR),
    .oPIX(oPIX), .oPIX_VLD(oPIX_VLD), .iWR_VALID(iWR_VALID), .oWR_READY(oWR_READY),
    .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .iWR_BE(iWR_BE),
    .iCLR_START(iCLR_START), .iCLR_COLOR(iCLR_COLOR), .oCLR_BUSY(oCLR_BUSY),
    .oADDR_ERR(oADDR_ERR), .oRAM_ADDR(oRAM_ADDR), .oRAM_WRITE(oRAM_WRITE),
    .oRAM_WDATA(oRAM_WDATA), .oRAM_BE(oRAM_BE), .oRAM_CLKEN(oRAM_CLKEN),
    .iRAM_RDATA(iRAM_RDATA)
  );

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    merge = old;
    if (be[0]) merge[7:0]  = d[7:0];
    if (be[1]) merge[15:8] = d[15:8];
  endfunction

  // RAM behind the port: synchronous read, write with byte enables
  logic [15:0] ram [int];
  int ram_writes = 0;
  always @(posedge clk) begin : ram_model
    int a;
    a = int'(oRAM_ADDR);
    iRAM_RDATA <= ram.exists(a) ? ram[a] : 16'h0;
    if (oRAM_WRITE) begin
      ram[a] = merge(ram.exists(a) ? ram[a] : 16'h0, oRAM_WDATA, oRAM_BE);
      ram_writes++;
    end
  end

  // Reference model state
  typedef struct packed {logic [16:0] addr; logic [15:0] data; logic [1:0] be;} wr_t;
  typedef struct {bit de; bit fetch; logic [15:0] pix;} pe_t;
  wr_t         wq[$];
  pe_t         pq[$];
  logic [15:0] ref_mem [int];
  logic [15:0] cur_pix;
  bit          err_exp;
  bit          fill_on;
  int          fill_cnt;
  logic [15:0] fill_color;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [15:0] mem_rd(input int a);
    mem_rd = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pe_t n;
    n.de = 0; n.fetch = 0; n.pix = 0;
    wq.delete();
    pq.delete();
    pq.push_back(n);
    pq.push_back(n);
    cur_pix = 0;
    err_exp = 0;
    fill_on = 0;
    fill_cnt = 0;
    fill_color = 0;
  endtask

  // One clock cycle: drive inputs, predict the port operation from the
  // priority rules, then check everything just after the edge.
  task automatic step(input bit de, input int h, input int v, input bit wv,
                      input logic [16:0] wa, input logic [15:0] wd, input logic [1:0] wb,
                      input bit cs, input logic [15:0] cc);
    bit fetch, ready_exp, exp_wr, busy_now;
    logic [16:0] exp_addr;
    logic [15:0] exp_wd;
    logic [1:0]  exp_be;
    pe_t e;
    wr_t hd, nw;
    iDE = de; iHADDR = 10'(h); iVADDR = 9'(v);
    iWR_VALID = wv; iWR_ADDR = wa; iWR_DATA = wd; iWR_BE = wb;
    iCLR_START = cs; iCLR_COLOR = cc;
    ready_exp = (wq.size() < 8);
    busy_now  = fill_on;
    chk("wr_ready", oWR_READY, ready_exp);
    chk("clr_busy", oCLR_BUSY, busy_now);
    fetch = de && (h % 2 == 0);
    exp_wr = 0; exp_addr = 0; exp_wd = 0; exp_be = 0;
    e.de = de; e.fetch = fetch; e.pix = 0;
    if (fetch) begin
      exp_addr = 17'((v / 2) * FB_W_T + h / 2);
      e.pix = mem_rd(int'(exp_addr));
    end else if (fill_on) begin
      exp_wr = 1; exp_addr = 17'(fill_cnt); exp_wd = fill_color; exp_be = 2'b11;
      fill_cnt++;
      if (fill_cnt == FB_SIZE_T) fill_on = 0;
    end else if (wq.size() > 0) begin
      hd = wq.pop_front();
      if (int'(hd.addr) < FB_SIZE_T) begin
        exp_wr = 1; exp_addr = hd.addr; exp_wd = hd.data; exp_be = hd.be;
      end else begin
        err_exp = 1;
      end
    end
    if (exp_wr) ref_mem[int'(exp_addr)] = merge(mem_rd(int'(exp_addr)), exp_wd, exp_be);
`ifdef FB_PORT_CLEAR_EN
    if (!busy_now && cs) begin
      fill_on = 1; fill_cnt = 0; fill_color = cc;
    end
`endif
    if (wv && ready_exp) begin
      nw.addr = wa; nw.data = wd; nw.be = wb;
      wq.push_back(nw);
    end
    pq.push_back(e);
    @(posedge clk); #1;
    chk("ram_write", oRAM_WRITE, exp_wr);
    chk("ram_addr", oRAM_ADDR, exp_addr);
    if (exp_wr) begin
      chk("ram_wdata", oRAM_WDATA, exp_wd);
      chk("ram_be", oRAM_BE, exp_be);
    end
    chk("addr_err", oADDR_ERR, err_exp);
    chk("ram_clken", oRAM_CLKEN, 1);
    e = pq.pop_front();
    if (e.fetch) cur_pix = e.pix;
    chk("pix", oPIX, cur_pix);
    chk("pix_vld", oPIX_VLD, e.de);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_ = 0;
    iDE = 0; iWR_VALID = 0; iCLR_START = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pix", oPIX, 0);
    chk("rst_pix_vld", oPIX_VLD, 0);
    chk("rst_wr_ready", oWR_READY, 1);
    chk("rst_clr_busy", oCLR_BUSY, 0);
    chk("rst_addr_err", oADDR_ERR, 0);
    chk("rst_ram_addr", oRAM_ADDR, 0);
    chk("rst_ram_write", oRAM_WRITE, 0);
    chk("rst_ram_wdata", oRAM_WDATA, 0);
    chk("rst_ram_be", oRAM_BE, 0);
    chk("rst_ram_clken", oRAM_CLKEN, 0);
    rst_ = 1;
    model_reset();
  endtask

  typedef struct {bit de; int h; int v; logic [16:0] exp_addr;} vec_t;

  initial begin
    vec_t tbl[7];
    int w0;
    int guard;
    int pix_a;
    pix_a = 2 * FB_W_T + 3;
    tbl[0] = '{1, 6, 5, 17'(2 * FB_W_T + 3)};
    tbl[1] = '{1, 0, 0, 17'(0)};
    tbl[2] = '{1, 7, 5, 17'(0)};
    tbl[3] = '{0, 6, 5, 17'(0)};
    tbl[4] = '{1, 4, 3, 17'(FB_W_T + 2)};
    tbl[5] = '{1, 2 * FB_W_T - 2, 2 * FB_H_T - 1, 17'(FB_SIZE_T - 1)};
    tbl[6] = '{1, FB_W_T, FB_H_T, 17'((FB_H_T / 2) * FB_W_T + FB_W_T / 2)};
    ram[pix_a] = 16'hABCD;
    ref_mem[pix_a] = 16'hABCD;

    do_reset();
    idle(2);

    // Reset while three writer entries are queued behind display fetches
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 17'(10 + i), 16'h7700 + 16'(i), 2'b11, 0, 0);
    do_reset();
    w0 = ram_writes;
    idle(4);
    chk("no_write_after_reset", ram_writes - w0, 0);

    // Display fetch address vectors
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].de, tbl[i].h, tbl[i].v, 0, 0, 0, 0, 0, 0);
      chk("tbl_addr", oRAM_ADDR, tbl[i].exp_addr);
      chk("tbl_write", oRAM_WRITE, 0);
      if (i == 2) begin
        chk("pix_abcd", oPIX, 16'hABCD);
        chk("pix_abcd_vld", oPIX_VLD, 1);
      end
    end
    idle(4);

    // Nine back-to-back pushes with every slot taken by display fetches
    w0 = ram_writes;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ready_low_when_full", oWR_READY, 0);
      step(1, 2 * (i % 4), 2, 1, 17'(100 + i), 16'h5000 + 16'(i), 2'b11, 0, 0);
    end
    idle(12);
    chk("drain_writes", ram_writes - w0, 8);
    chk("drain_last_word", ram[107], 16'h5007);

    // Out-of-range write
    w0 = ram_writes;
    step(0, 0, 0, 1, 17'(FB_SIZE_T), 16'h1234, 2'b11, 0, 0);
    idle(3);
    chk("addr_err_set", oADDR_ERR, 1);
    chk("oor_no_write", ram_writes - w0, 0);

`ifdef FB_PORT_CLEAR_EN
    // Fill in blanking with one writer entry queued during the fill
    w0 = ram_writes;
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'hF800);
    step(0, 0, 0, 1, 17'd50, 16'h0BEE, 2'b11, 0, 0);
    guard = 0;
    while (oCLR_BUSY && guard < 3 * FB_SIZE_T) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("fill_done_in_time", oCLR_BUSY, 0);
    idle(4);
    chk("fill_write_count", ram_writes - w0, FB_SIZE_T + 1);
    chk("fill_last_word", ram[FB_SIZE_T - 1], 16'hF800);
    chk("fifo_after_fill", ram[50], 16'h0BEE);
`else
    // Fill engine absent: start pulse must do nothing
    w0 = ram_writes;
    step(0, 0, 0, 0, 0, 0, 0, 1, 16'hF800);
    idle(5);
    chk("no_fill_writes", ram_writes - w0, 0);
    chk("no_fill_busy", oCLR_BUSY, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit rde, rwv, rcs;
      int rh, rv;
      logic [16:0] ra;
      rde = ($urandom_range(0, 3) != 0);
      rh  = $urandom_range(0, 2 * FB_W_T - 1);
      rv  = $urandom_range(0, 2 * FB_H_T - 1);
      rwv = $urandom_range(0, 1) == 1;
      ra  = ($urandom_range(0, 19) == 0) ? 17'(FB_SIZE_T + $urandom_range(0, 9))
                                         : 17'($urandom_range(0, FB_SIZE_T - 1));
      rcs = ($urandom_range(0, 499) == 0);
      step(rde, rh, rv, rwv, ra, 16'($urandom), 2'($urandom), rcs, 16'($urandom));
    end
    guard = 0;
    while ((wq.size() > 0 || fill_on) && guard < 3000) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("random_drained", wq.size() + int'(fill_on), 0);
    chk("addr_err_sticky", oADDR_ERR, 1);

    do_reset();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
